inst_fetch: RTL
===============

Name: inst_fetch

Overview:
- Instruction fetch front end: the requester side of the word-addressed, combinational-read instruction memory port (read_addr[29:0] out, memout[31:0] back in the same cycle).
- Owns the fetch PC and drives the memory address.
- Captures returned words into a small prefetch FIFO and hands {pc, instr} to decode over a valid/ready handshake.
- Accepts branch/jump redirects from later stages.

Parameters:
- RESET_PC, 32'h0040_0000, byte address of the first fetch after reset (word address 30'h0010_0000).
- DEPTH, 4, prefetch FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- read_addr  output  30  word address to instruction memory = fetch_pc[31:2]; combinational from fetch_pc.
- memout  input  32  instruction word from memory; valid in the same cycle as read_addr.
- redirect  input  1  load new fetch target this cycle.
- redirect_pc  input  32  byte target for redirect.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  decode accepts head this cycle.
- out_pc  output  32  byte PC of head instruction; 0 when out_valid=0.
- out_instr  output  32  head instruction word; 0 when out_valid=0.
- fault  output  1  misaligned-redirect trap; only with the optional feature, else tied 0.

Behaviour:
- State:
  - fetch_pc[31:0].
  - FIFO storage of DEPTH x {pc[31:0], instr[31:0]}.
  - rd_ptr and wr_ptr, log2(DEPTH) bits, wrap modulo DEPTH.
  - count, log2(DEPTH)+1 bits.
- Reset (rst_n=0 at edge), overrides everything incl. redirect:
  - fetch_pc=RESET_PC; rd_ptr=wr_ptr=count=0; fault=0.
  - Outputs after reset edge: out_valid=0, out_pc=0, out_instr=0, read_addr=RESET_PC[31:2].
  - Reset mid-operation discards all FIFO contents.
- out_valid = (count != 0). out_pc/out_instr = head entry when valid, else 0.
- pop = out_valid & out_ready.
- push = !redirect & (count < DEPTH | pop).
  - Full FIFO plus a same-cycle pop still pushes.
  - On push: entry[wr_ptr] = {fetch_pc, memout}; wr_ptr++; fetch_pc += 4 (wraps modulo 2^32, no flag).
- Count update: push&!pop -> +1; pop&!push -> -1; both or neither -> unchanged.
- Empty with no push: out_valid stays 0. Full with no pop: fetch_pc and read_addr hold.
- Redirect (highest priority after reset):
  - rd_ptr=wr_ptr=count=0; fetch_pc=redirect_pc with bits [1:0] forced to 0.
  - No push that cycle; a same-cycle pop is honoured by decode, but the FIFO is flushed anyway.
  - Next cycle: out_valid=0, read_addr=redirect_pc[31:2], target word pushed.
  - Cycle after that: out_valid=1 with out_pc=target.
- Latency:
  - Memory word to out_valid is 1 edge.
  - Redirect to first target instruction is 2 edges.
  - Steady state with out_ready=1 is 1 instruction/cycle.
- No combinational path from out_ready or redirect to read_addr; read_addr depends on fetch_pc only.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined:
  - A redirect with redirect_pc[1:0] != 0 flushes the FIFO as usual and sets fault=1 (sticky until reset).
  - fetch_pc = redirect_pc & ~3.
  - While fault=1: push is forced 0, further redirects are ignored, and out_valid stays 0.
- Undefined:
  - fault is constant 0.
  - Low two target bits are silently dropped and fetch proceeds normally.

Test Plan:
- Reset then rst_n=1, out_ready=1, memory mem[w]=w^32'hA5A5_0000:
  - read_addr=30'h0010_0000 in the first cycle.
  - Next cycle: out_valid=1, out_pc=32'h0040_0000, out_instr=32'hA5B5_0000.
  - out_pc then increments by 4 every cycle.
- out_ready=0 for 8 cycles from reset: count saturates at 4, read_addr holds 30'h0010_0004, out_pc holds 32'h0040_0000. Then out_ready=1: pcs 0x00400000..0x0040000C drain in order, followed by 0x00400010 with no gap.
- FIFO holding 3 entries, redirect=1, redirect_pc=32'h0040_0020: next cycle out_valid=0 and read_addr=30'h0010_0008; following cycle out_pc=32'h0040_0020.
- FIFO full with out_ready=1 and redirect in the same cycle: head is accepted, then out_valid=0 for 1 cycle, no stale pc reappears, and out_pc=32'h0040_0020 next.
- rst_n=0 for one edge while count=3 and fetch_pc=0x00400030: out_valid=0, out_pc=0, read_addr=30'h0010_0000, and a redirect asserted in that cycle is ignored.
- redirect_pc=32'h0040_0022:
  - MISALIGN_TRAP_EN: fault=1, out_valid stays 0 for 10 cycles, a later redirect to 0x00400000 is ignored.
  - Without the macro: out_pc=32'h0040_0020, fault=0.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch front end: owns the fetch PC, captures memory words into a
// prefetch FIFO and presents {pc, instr} to decode. Optional macro: MISALIGN_TRAP_EN.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [29:0] read_addr,
  input  logic [31:0] memout,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fault
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   fifo_pc_q    [DEPTH];
  logic [31:0]   fifo_pc_d    [DEPTH];
  logic [31:0]   fifo_instr_q [DEPTH];
  logic [31:0]   fifo_instr_d [DEPTH];

  logic pop;
  logic push;
  logic redirect_eff;
  logic fetch_en;

`ifdef MISALIGN_TRAP_EN
  logic fault_q, fault_d;

  // Once trapped, the front end goes silent until reset.
  assign redirect_eff = redirect & ~fault_q;
  assign fetch_en     = ~fault_q;
  assign fault        = fault_q;
`else
  assign redirect_eff = redirect;
  assign fetch_en     = 1'b1;
  assign fault        = 1'b0;
`endif

  assign read_addr = fetch_pc_q[31:2];
  assign out_valid = (count_q != '0) & fetch_en;
  assign out_pc    = out_valid ? fifo_pc_q[rd_ptr_q]    : 32'h0;
  assign out_instr = out_valid ? fifo_instr_q[rd_ptr_q] : 32'h0;

  assign pop  = out_valid & out_ready;
  assign push = ~redirect_eff & fetch_en & ((count_q < DEPTH_C) | pop);

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;
`ifdef MISALIGN_TRAP_EN
    fault_d      = fault_q;
`endif

    if (redirect_eff) begin
      // A same-cycle pop has already been seen by decode; the flush drops the rest.
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc & ~32'h3;
`ifdef MISALIGN_TRAP_EN
      fault_d    = fault_q | (redirect_pc[1:0] != 2'b00);
`endif
    end else begin
      if (push) begin
        fifo_pc_d[wr_ptr_q]    = fetch_pc_q;
        fifo_instr_d[wr_ptr_q] = memout;
        wr_ptr_d               = wr_ptr_q + AW'(1);
        fetch_pc_d             = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + (AW + 1)'(1);
      end else if (pop && !push) begin
        count_d = count_q - (AW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
`ifdef MISALIGN_TRAP_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
`ifdef MISALIGN_TRAP_EN
      fault_q    <= fault_d;
`endif
    end
  end

  // Entry storage needs no reset: count gates visibility.
  always_ff @(posedge clk) begin
    fifo_pc_q    <= fifo_pc_d;
    fifo_instr_q <= fifo_instr_d;
  end

endmodule
